// File: rtl/ray_setup.sv
// Per-column ray setup for a raycaster: sweeps the camera plane and emits one ray per column, 2 cycles after issue.
// Backpressure: ray_valid && !ray_ready freezes the issue counter and both pipeline stages; outputs hold.
module ray_setup #(
    parameter int SCREEN_WIDTH = 320,
    parameter int CAM_STEP     = 410
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start,
    input  logic [15:0] posX,
    input  logic [15:0] posY,
    input  logic [15:0] dirX,
    input  logic [15:0] dirY,
    input  logic [15:0] planeX,
    input  logic [15:0] planeY,
    output logic        ray_valid,
    input  logic        ray_ready,
    output logic [8:0]  col_x,
    output logic [15:0] rayDirX,
    output logic [15:0] rayDirY,
    output logic [7:0]  mapX,
    output logic [7:0]  mapY,
    output logic        stepX_neg,
    output logic        stepY_neg,
    output logic [8:0]  fracX,
    output logic [8:0]  fracY,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    localparam logic [23:0] CAM_STEP_Q = 24'(CAM_STEP);
    localparam logic [8:0]  LAST_COL   = 9'(SCREEN_WIDTH - 1);

    state_t state_q, state_d;
    logic [8:0]  col_q, col_d;
    logic [23:0] acc_q, acc_d;
    logic [15:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [15:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [15:0] plane_x_q, plane_x_d, plane_y_q, plane_y_d;

    logic        s1_vld_q, s1_vld_d;
    logic [8:0]  s1_col_q, s1_col_d;
    logic [15:0] s1_off_x_q, s1_off_x_d, s1_off_y_q, s1_off_y_d;

    logic        ray_valid_q, ray_valid_d;
    logic [8:0]  out_col_q, out_col_d;
    logic [15:0] ray_dir_x_q, ray_dir_x_d, ray_dir_y_q, ray_dir_y_d;
    logic [7:0]  map_x_q, map_x_d, map_y_q, map_y_d;
    logic        step_x_neg_q, step_x_neg_d, step_y_neg_q, step_y_neg_d;
    logic [8:0]  frac_x_q, frac_x_d, frac_y_q, frac_y_d;

    logic               advance;
    logic               issue;
    logic signed [15:0] cam_x;
    logic signed [31:0] prod_x, prod_y;
    logic [15:0]        sum_x, sum_y;
    logic               unused_bits;

    // One global stall: a held output ray freezes everything upstream.
    assign advance = !(ray_valid_q && !ray_ready);
    assign issue   = (state_q == SWEEP) && advance;
    assign cam_x   = $signed(acc_q[23:8]);
    assign prod_x  = $signed(plane_x_q) * cam_x;
    assign prod_y  = $signed(plane_y_q) * cam_x;
    assign sum_x   = dir_x_q + s1_off_x_q;
    assign sum_y   = dir_y_q + s1_off_y_q;
    assign unused_bits = ^{acc_q[7:0], prod_x[31:24], prod_x[7:0], prod_y[31:24], prod_y[7:0]};

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        acc_d     = acc_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        plane_x_d = plane_x_q;
        plane_y_d = plane_y_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    pos_x_d   = posX;
                    pos_y_d   = posY;
                    dir_x_d   = dirX;
                    dir_y_d   = dirY;
                    plane_x_d = planeX;
                    plane_y_d = planeY;
                    col_d     = 9'd0;
                    acc_d     = 24'hFF0000;
                    state_d   = SWEEP;
                end
            end
            SWEEP: begin
                if (issue) begin
                    col_d = col_q + 9'd1;
                    acc_d = acc_q + CAM_STEP_Q;
                    if (col_q == LAST_COL) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_vld_q && !ray_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_vld_d     = s1_vld_q;
        s1_col_d     = s1_col_q;
        s1_off_x_d   = s1_off_x_q;
        s1_off_y_d   = s1_off_y_q;
        ray_valid_d  = ray_valid_q;
        out_col_d    = out_col_q;
        ray_dir_x_d  = ray_dir_x_q;
        ray_dir_y_d  = ray_dir_y_q;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        step_x_neg_d = step_x_neg_q;
        step_y_neg_d = step_y_neg_q;
        frac_x_d     = frac_x_q;
        frac_y_d     = frac_y_q;
        if (advance) begin
            s1_vld_d = issue;
            if (issue) begin
                s1_col_d   = col_q;
                s1_off_x_d = prod_x[23:8];
                s1_off_y_d = prod_y[23:8];
            end
            ray_valid_d = s1_vld_q;
            if (s1_vld_q) begin
                out_col_d    = s1_col_q;
                ray_dir_x_d  = sum_x;
                ray_dir_y_d  = sum_y;
                map_x_d      = pos_x_q[15:8];
                map_y_d      = pos_y_q[15:8];
                step_x_neg_d = sum_x[15];
                step_y_neg_d = sum_y[15];
                // Distance to the next grid line: the fraction itself going negative, its complement going positive.
                frac_x_d     = sum_x[15] ? {1'b0, pos_x_q[7:0]} : 9'h100 - {1'b0, pos_x_q[7:0]};
                frac_y_d     = sum_y[15] ? {1'b0, pos_y_q[7:0]} : 9'h100 - {1'b0, pos_y_q[7:0]};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            col_q        <= 9'd0;
            acc_q        <= 24'd0;
            pos_x_q      <= 16'd0;
            pos_y_q      <= 16'd0;
            dir_x_q      <= 16'd0;
            dir_y_q      <= 16'd0;
            plane_x_q    <= 16'd0;
            plane_y_q    <= 16'd0;
            s1_vld_q     <= 1'b0;
            s1_col_q     <= 9'd0;
            s1_off_x_q   <= 16'd0;
            s1_off_y_q   <= 16'd0;
            ray_valid_q  <= 1'b0;
            out_col_q    <= 9'd0;
            ray_dir_x_q  <= 16'd0;
            ray_dir_y_q  <= 16'd0;
            map_x_q      <= 8'd0;
            map_y_q      <= 8'd0;
            step_x_neg_q <= 1'b0;
            step_y_neg_q <= 1'b0;
            frac_x_q     <= 9'd0;
            frac_y_q     <= 9'd0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            acc_q        <= acc_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            plane_x_q    <= plane_x_d;
            plane_y_q    <= plane_y_d;
            s1_vld_q     <= s1_vld_d;
            s1_col_q     <= s1_col_d;
            s1_off_x_q   <= s1_off_x_d;
            s1_off_y_q   <= s1_off_y_d;
            ray_valid_q  <= ray_valid_d;
            out_col_q    <= out_col_d;
            ray_dir_x_q  <= ray_dir_x_d;
            ray_dir_y_q  <= ray_dir_y_d;
            map_x_q      <= map_x_d;
            map_y_q      <= map_y_d;
            step_x_neg_q <= step_x_neg_d;
            step_y_neg_q <= step_y_neg_d;
            frac_x_q     <= frac_x_d;
            frac_y_q     <= frac_y_d;
        end
    end

    assign ray_valid  = ray_valid_q;
    assign col_x      = out_col_q;
    assign rayDirX    = ray_dir_x_q;
    assign rayDirY    = ray_dir_y_q;
    assign mapX       = map_x_q;
    assign mapY       = map_y_q;
    assign stepX_neg  = step_x_neg_q;
    assign stepY_neg  = step_y_neg_q;
    assign fracX      = frac_x_q;
    assign fracY      = frac_y_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DRAIN) && !s1_vld_q && !ray_valid_q;

endmodule

// File: tb/tb_ray_setup.sv
// Bench for ray_setup: closed-form per-column model plus directed literal checks.
module tb_ray_setup;
    localparam int SW = 320;
    localparam int CS = 410;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        frame_start = 1'b0;
    logic        ray_ready = 1'b1;
    logic [15:0] posX = '0, posY = '0, dirX = '0, dirY = '0, planeX = '0, planeY = '0;
    logic        ray_valid, stepX_neg, stepY_neg, busy, frame_done;
    logic [8:0]  col_x, fracX, fracY;
    logic [15:0] rayDirX, rayDirY;
    logic [7:0]  mapX, mapY;

    ray_setup #(.SCREEN_WIDTH(SW), .CAM_STEP(CS)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start),
        .posX(posX), .posY(posY), .dirX(dirX), .dirY(dirY), .planeX(planeX), .planeY(planeY),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .col_x(col_x),
        .rayDirX(rayDirX), .rayDirY(rayDirY), .mapX(mapX), .mapY(mapY),
        .stepX_neg(stepX_neg), .stepY_neg(stepY_neg), .fracX(fracX), .fracY(fracY),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, exp_col = 0;
    bit rand_mode = 0;
    logic [15:0] s_posX = '0, s_posY = '0, s_dirX = '0, s_dirY = '0, s_planeX = '0, s_planeY = '0;
    logic [76:0] prev_out = '0;
    bit prev_stall = 0;
    wire [76:0] dut_out = {col_x, rayDirX, rayDirY, mapX, mapY, stepX_neg, stepY_neg, fracX, fracY};

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Column c of the sweep in closed form: camera x = -1 + c*step, ray = dir + plane*camera.
    function automatic logic [76:0] model_ray(input int c);
        int acc, cam, ox, oy;
        logic [15:0] rdx, rdy;
        logic [8:0] fx, fy;
        acc = -65536 + c * CS;
        cam = acc >>> 8;
        ox  = (int'($signed(s_planeX)) * cam) >>> 8;
        oy  = (int'($signed(s_planeY)) * cam) >>> 8;
        rdx = 16'(int'($signed(s_dirX)) + ox);
        rdy = 16'(int'($signed(s_dirY)) + oy);
        fx  = rdx[15] ? {1'b0, s_posX[7:0]} : 9'(256 - int'(s_posX[7:0]));
        fy  = rdy[15] ? {1'b0, s_posY[7:0]} : 9'(256 - int'(s_posY[7:0]));
        return {9'(c), rdx, rdy, s_posX[15:8], s_posY[15:8], rdx[15], rdy[15], fx, fy};
    endfunction

    always @(negedge clk_in) begin
        if (!rst_in) begin
            exp_col = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("stall_hold", {ray_valid, dut_out}, {1'b1, prev_out});
            if (ray_valid) begin
                chk("ray", dut_out, model_ray(exp_col));
                if (ray_ready) exp_col++;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("frame_rays", exp_col, SW);
                exp_col = 0;
            end
            prev_stall = ray_valid && !ray_ready;
            prev_out = dut_out;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rand_mode) ray_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_frame(input logic [15:0] px, py, dx, dy, plx, ply);
        posX = px; posY = py; dirX = dx; dirY = dy; planeX = plx; planeY = ply;
        s_posX = px; s_posY = py; s_dirX = dx; s_dirY = dy; s_planeX = plx; s_planeY = ply;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n0 = done_cnt;
        int k = 0;
        while (done_cnt == n0 && k < budget) begin
            tick();
            k++;
        end
        chk("frame_done_seen", done_cnt, n0 + 1);
    endtask

    task automatic wait_col(input int c, input int budget);
        int k = 0;
        while (!(ray_valid && col_x == 9'(c)) && k < budget) begin
            tick();
            k++;
        end
        chk("reach_col", k < budget, 1'b1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        chk("rst_valid", ray_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_payload", dut_out, 77'd0);
        rst_in = 1'b1;
        tick();

        // Reference frame with literal expectations
        start_frame(16'h0280, 16'h0340, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
        chk("c0_valid", ray_valid, 1'b0);
        tick();
        chk("c1_valid", ray_valid, 1'b0);
        chk("c1_busy", busy, 1'b1);
        tick();
        chk("c2_valid", ray_valid, 1'b1);
        chk("c2_col", col_x, 9'd0);
        chk("c2_dir", {rayDirX, rayDirY}, {16'hFF00, 16'hFF57});
        chk("c2_map", {mapX, mapY}, {8'd2, 8'd3});
        chk("c2_step", {stepX_neg, stepY_neg}, 2'b11);
        chk("c2_frac", {fracX, fracY}, {9'h080, 9'h040});
        wait_col(160, 400);
        chk("c160_dir", {rayDirX, rayDirY}, {16'hFF00, 16'h0000});
        chk("c160_stepy", stepY_neg, 1'b0);
        chk("c160_fracy", fracY, 9'h0C0);
        wait_done(400);
        chk("done_cycle", done_cyc - start_cyc, 322);
        tick();
        chk("idle_busy", busy, 1'b0);

        // Random backpressure over a full frame
        rand_mode = 1;
        start_frame(16'h1234, 16'h0500, 16'h0100, 16'h0080, 16'hFFAB, 16'h0055);
        wait_done(3000);
        rand_mode = 0;
        ray_ready = 1'b1;

        // Mid-frame input change and ignored frame_start
        start_frame(16'h0A80, 16'h0F10, 16'h0080, 16'hFF80, 16'hFF00, 16'h0100);
        wait_col(100, 400);
        posX = 16'h7777; posY = 16'h1111; dirX = 16'h4000; dirY = 16'hC000;
        planeX = 16'h2222; planeY = 16'h9999;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_done(400);
        n = done_cnt;
        repeat (5) tick();
        chk("no_extra_frame_busy", busy, 1'b0);
        chk("no_extra_frame_done", done_cnt, n);

        // Reset mid-frame
        start_frame(16'h0280, 16'h0340, 16'hFF00, 16'h0000, 16'h0000, 16'h00A9);
        wait_col(50, 400);
        rst_in = 1'b0;
        tick();
        chk("midrst_valid", ray_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_payload", dut_out, 77'd0);
        rst_in = 1'b1;
        n = done_cnt;
        repeat (400) tick();
        chk("midrst_no_done", done_cnt, n);

        // Integer-aligned position: positive and negative step
        start_frame(16'h0500, 16'h0180, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
        tick();
        tick();
        chk("pos_col0", {ray_valid, col_x}, {1'b1, 9'd0});
        chk("pos_fracx", {stepX_neg, fracX}, {1'b0, 9'h100});
        wait_done(400);
        start_frame(16'h0500, 16'h0180, 16'hFF00, 16'h0100, 16'h0000, 16'h0000);
        tick();
        tick();
        chk("neg_fracx", {stepX_neg, fracX}, {1'b1, 9'h000});
        wait_done(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ray_setup.md
RAY_SETUP -- requirements
Module: ray_setup

Interface
REQ-001 Parameter SCREEN_WIDTH, default 320, number of screen columns per frame (2..511).
REQ-002 Parameter CAM_STEP, default round(131072/SCREEN_WIDTH) = 410, camera-plane increment per column in Q8.16.
REQ-003 clk_in  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst_in  input  1  reset; synchronous and active-low.
REQ-005 frame_start  input  1  one-cycle pulse that starts a column sweep.
REQ-006 posX, posY  input  16  player position, Q8.8 unsigned.
REQ-007 dirX, dirY, planeX, planeY  input  16 each  direction and camera-plane vectors, Q8.8 signed.
REQ-008 ray_valid  output  1  ray outputs hold a valid ray.
REQ-009 ray_ready  input  1  downstream DDA accepts the ray.
REQ-010 col_x  output  9  column index of the ray.
REQ-011 rayDirX, rayDirY  output  16 each  ray direction, Q8.8 signed.
REQ-012 mapX, mapY  output  8 each  integer grid cell of the position.
REQ-013 stepX_neg, stepY_neg  output  1 each  1 = step -1, 0 = step +1.
REQ-014 fracX, fracY  output  9 each  distance to the first grid line along each axis, Q1.8.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 frame_done  output  1  one-cycle pulse once the last ray of the frame is accepted.

Function
REQ-017 The FSM SHALL have three states: IDLE, SWEEP and DRAIN.
REQ-018 IDLE + frame_start: snapshot all six vector inputs, col=0, camera accumulator=-1.0 (Q8.16 0xFF0000, 24-bit signed), go to SWEEP.
REQ-019 frame_start while not in IDLE SHALL be ignored; the snapshot SHALL NOT change mid-frame.
REQ-020 SWEEP: issue one column per unstalled cycle, then col+=1 and acc+=CAM_STEP.
REQ-021 After column SCREEN_WIDTH-1 is issued, go to DRAIN.
REQ-022 DRAIN: when the pipeline is empty, pulse frame_done for one cycle and return to IDLE.
REQ-023 cameraX SHALL equal acc[23:8] (Q8.8 signed).
REQ-024 Stage 1: products planeX*cameraX and planeY*cameraX, signed 16x16 to 32 bits.
REQ-025 Stage 1 output SHALL be product bits [23:8], truncated, not rounded.
REQ-026 Stage 2: rayDir = dir + stage-1 result, 16-bit two's complement with wrap and no saturation.
REQ-027 Stage 2: mapX=posX[15:8], mapY=posY[15:8]; stepX_neg=rayDirX[15], stepY_neg=rayDirY[15].
REQ-028 Stage 2 fracX: step negative -> {1'b0,posX[7:0]}; step positive -> 9'h100 - posX[7:0] (9'h100 when the fraction is 0); fracY likewise.
REQ-029 Latency: the ray SHALL appear on the outputs 2 cycles after its column is issued, absent stalls.
REQ-030 Handshake: a ray transfers on the cycle where ray_valid and ray_ready are both 1.
REQ-031 ray_valid && !ray_ready SHALL stall the whole pipeline and the issue counter; outputs SHALL stay stable and no ray may be dropped or duplicated.
REQ-032 The pipeline SHALL sustain one ray per cycle with ray_ready held high; a full frame takes SCREEN_WIDTH+2 cycles from frame_start to frame_done (includes the 2-cycle pipeline latency).
REQ-033 Rays SHALL leave in strictly increasing col_x order, 0..SCREEN_WIDTH-1, exactly once per frame.

Reset
REQ-034 While rst_in=0 at a clock edge, the FSM SHALL go to IDLE and all pipeline valid flags SHALL clear.
REQ-035 Every output SHALL be 0 during reset, including ray_valid, busy and frame_done.
REQ-036 Reset mid-frame SHALL abandon the frame with no frame_done; the next frame_start after release SHALL start again at col 0.

Verification
REQ-037 Inputs pos=(0x0280,0x0340), dir=(0xFF00,0x0000), plane=(0x0000,0x00A9), ready=1, frame_start -> col 0: rayDir=(0xFF00,0xFF57), map=(2,3), stepX_neg=1, stepY_neg=1, frac=(0x080,0x040), on cycle 2.
REQ-038 Same inputs, col 160 -> acc=64 and cameraX=0x0000; rayDirY=0x0000, stepY_neg=0, fracY=0x0C0; col 319 is the last ray, and frame_done follows at cycle 322.
REQ-039 Random ray_ready toggling for a full frame -> 320 rays in order, each accepted once, with ray outputs stable throughout every stall.
REQ-040 Inputs changed and frame_start pulsed at col 100 -> every ray of the frame uses the original snapshot; the extra frame_start is ignored.
REQ-041 rst_in=0 at col 50, then released -> ray_valid=0 next cycle, no frame_done; a new frame_start restarts at col 0.
REQ-042 posX=0x0500 with rayDirX positive -> fracX=0x100; with rayDirX negative -> fracX=0x000.
